// File: rtl/dma_pkg.sv
// dma_pkg: shared definitions for the DMA slave-port arbiter family.
//   - arbiter state encoding (also exposed as plain localparams)
//   - read/write encoding of the byte write enables
//   - data-path width
package dma_pkg;

    localparam int DW = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    // Byte write enables of all zero mean the beat is a read.
    localparam logic [1:0] WEN_READ = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_OWN0 = ST_OWN0,
        S_OWN1 = ST_OWN1
    } arb_state_e;

    function automatic logic is_read(input logic [1:0] wen);
        return wen == WEN_READ;
    endfunction

endpackage

// File: rtl/dma_slave_arbiter_if.sv
// dma_slave_arbiter_if: bundles both requester ports, the shared read
// return path and the single-port AHB slave memory port.
//   modport slave  : the arbiter's view (takes requests, drives the memory)
//   modport master : the surrounding system (requesters + slave memory)
interface dma_slave_arbiter_if #(
    parameter int AW = 16
);
    // requester 0 (DMA engine)
    logic                    m0_req;
    logic                    m0_lock;
    logic [AW-1:0]           m0_addr;
    logic [1:0]              m0_wen;
    logic [dma_pkg::DW-1:0]  m0_din;
    logic                    m0_ack;
    logic                    m0_rvalid;
    // requester 1 (CPU / debug path)
    logic                    m1_req;
    logic                    m1_lock;
    logic [AW-1:0]           m1_addr;
    logic [1:0]              m1_wen;
    logic [dma_pkg::DW-1:0]  m1_din;
    logic                    m1_ack;
    logic                    m1_rvalid;
    // shared read return
    logic [dma_pkg::DW-1:0]  rdata;
    logic                    rresp;
    // slave memory port
    logic [AW-1:0]           ahb_slave_addr;
    logic                    ahb_slave_en;
    logic [1:0]              ahb_slave_wen;
    logic [dma_pkg::DW-1:0]  ahb_slave_din;
    logic                    ahb_slave_ready;
    logic [dma_pkg::DW-1:0]  ahb_slave_dout;
    logic                    ahb_slave_resp;

    modport slave (
        input  m0_req, m0_lock, m0_addr, m0_wen, m0_din,
        output m0_ack, m0_rvalid,
        input  m1_req, m1_lock, m1_addr, m1_wen, m1_din,
        output m1_ack, m1_rvalid,
        output rdata, rresp,
        output ahb_slave_addr, ahb_slave_en, ahb_slave_wen, ahb_slave_din,
        input  ahb_slave_ready, ahb_slave_dout, ahb_slave_resp
    );

    modport master (
        output m0_req, m0_lock, m0_addr, m0_wen, m0_din,
        input  m0_ack, m0_rvalid,
        output m1_req, m1_lock, m1_addr, m1_wen, m1_din,
        input  m1_ack, m1_rvalid,
        input  rdata, rresp,
        input  ahb_slave_addr, ahb_slave_en, ahb_slave_wen, ahb_slave_din,
        output ahb_slave_ready, ahb_slave_dout, ahb_slave_resp
    );

endinterface

// File: rtl/dma_rr_pick.sv
// dma_rr_pick: two-input round-robin picker.
//   req        in  2  request vector, bit i = requester i
//   last_owner in  1  requester that held the port most recently
//   grant      out 2  one-hot winner (all zero when nobody requests)
// On contention the requester that did not own the port last wins.
module dma_rr_pick (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic [1:0] grant
);

    always_comb begin
        // NOTE: a default on every path keeps always_comb free of latches.
        grant = req;
        if (req == 2'b11) begin
            grant = last_owner ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dma_slave_arbiter.sv
// dma_slave_arbiter: shares one single-port slave memory (16-bit data,
// byte write enables, 1-cycle synchronous read) between two requesters.
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   bus      dma_slave_arbiter_if.slave
//              m0_* / m1_*   requester handshakes (req, lock, addr, wen,
//                            din in; ack, rvalid out)
//              rdata, rresp  read return shared by both requesters
//              ahb_slave_*   memory port; ready/resp passed through
// Ownership is round-robin; an owner may hold the port for up to MAX_BURST
// consecutive accepted beats by asserting lock. The memory-side mux and the
// acks are combinational from the registered owner state.
module dma_slave_arbiter
    import dma_pkg::*;
#(
    parameter int MAX_BURST = 8,
    parameter int AW        = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    dma_slave_arbiter_if.slave bus
);

    arb_state_e      state;
    logic            last_owner;
    logic [7:0]      cnt;
    logic [1:0]      rvalid_q;
    logic [DW-1:0]   rdata_q;
    logic            rresp_q;

    logic [1:0]      grant;
    logic            own_req;
    logic            own_lock;
    logic [AW-1:0]   own_addr;
    logic [1:0]      own_wen;
    logic [DW-1:0]   own_din;
    logic            other_req;
    logic            beat_ack;
    logic            ack0;
    logic            ack1;
    logic            last_beat;
    logic            release_own;

    // Arbitration from IDLE only; handover between owners never needs a
    // tie-break because the releasing owner is excluded by definition.
    dma_rr_pick u_pick (
        .req        ({bus.m1_req, bus.m0_req}),
        .last_owner (last_owner),
        .grant      (grant)
    );

    // Select the owning requester's beat; IDLE drives an all-zero port.
    always_comb begin
        own_req   = 1'b0;
        own_lock  = 1'b0;
        own_addr  = '0;
        own_wen   = WEN_READ;
        own_din   = '0;
        other_req = 1'b0;
        case (state)
            S_OWN0: begin
                own_req   = bus.m0_req;
                own_lock  = bus.m0_lock;
                own_addr  = bus.m0_addr;
                own_wen   = bus.m0_wen;
                own_din   = bus.m0_din;
                other_req = bus.m1_req;
            end
            S_OWN1: begin
                own_req   = bus.m1_req;
                own_lock  = bus.m1_lock;
                own_addr  = bus.m1_addr;
                own_wen   = bus.m1_wen;
                own_din   = bus.m1_din;
                other_req = bus.m0_req;
            end
            default: begin
            end
        endcase
    end

    assign beat_ack  = own_req & bus.ahb_slave_ready;
    assign ack0      = (state == S_OWN0) & beat_ack;
    assign ack1      = (state == S_OWN1) & beat_ack;
    assign last_beat = (cnt == 8'(MAX_BURST - 1));

    // The owner lets go when it stops requesting, after an unlocked beat,
    // or on the beat that uses up the burst allowance.
    assign release_own = (state != S_IDLE) &
                         (~own_req | (beat_ack & (~own_lock | last_beat)));

    assign bus.ahb_slave_en   = own_req;
    assign bus.ahb_slave_wen  = own_wen & {2{own_req}};
    assign bus.ahb_slave_addr = own_addr;
    assign bus.ahb_slave_din  = own_din;
    assign bus.m0_ack         = ack0;
    assign bus.m1_ack         = ack1;

    // Owner FSM, burst counter and round-robin history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            last_owner <= 1'b1;
            cnt        <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            case (state)
                S_IDLE: begin
                    if (grant[0]) begin
                        state <= S_OWN0;
                    end else if (grant[1]) begin
                        state <= S_OWN1;
                    end
                end
                S_OWN0, S_OWN1: begin
                    if (release_own) begin
                        last_owner <= (state == S_OWN1);
                        cnt        <= '0;
                        if (other_req) begin
                            state <= (state == S_OWN0) ? S_OWN1 : S_OWN0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (beat_ack && (cnt < 8'(MAX_BURST))) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read return tag. Registered per requester so the data lands with the
    // right requester even when ownership flips on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
            rresp_q  <= 1'b0;
        end else begin
            rvalid_q <= {ack1 & is_read(bus.m1_wen), ack0 & is_read(bus.m0_wen)};
            if (|rvalid_q) begin
                rdata_q <= bus.ahb_slave_dout;
                rresp_q <= bus.ahb_slave_resp;
            end
        end
    end

    // The slave's data is only valid in the cycle after the read beat, so
    // it is forwarded live while a tag is pending and held afterwards.
    assign bus.m0_rvalid = rvalid_q[0];
    assign bus.m1_rvalid = rvalid_q[1];
    assign bus.rdata     = (|rvalid_q) ? bus.ahb_slave_dout : rdata_q;
    assign bus.rresp     = (|rvalid_q) ? bus.ahb_slave_resp : rresp_q;

endmodule

// File: tb/tb_dma_slave_arbiter.sv
// tb_dma_slave_arbiter: directed scenarios plus a randomized run, all
// checked cycle by cycle against a transaction-level reference model
// (owner / burst allowance / pending read / reference memory).
module tb_dma_slave_arbiter;
    import dma_pkg::*;

    localparam int MAX_BURST = 8;
    localparam int AW        = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    dma_slave_arbiter_if #(.AW(AW)) bus ();

    dma_slave_arbiter #(.MAX_BURST(MAX_BURST), .AW(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ---------------- requester stimulus ----------------
    logic          req_v  [2];
    logic          lock_v [2];
    logic [AW-1:0] addr_v [2];
    logic [1:0]    wen_v  [2];
    logic [15:0]   din_v  [2];
    logic          rdy;

    assign bus.m0_req  = req_v[0];
    assign bus.m0_lock = lock_v[0];
    assign bus.m0_addr = addr_v[0];
    assign bus.m0_wen  = wen_v[0];
    assign bus.m0_din  = din_v[0];
    assign bus.m1_req  = req_v[1];
    assign bus.m1_lock = lock_v[1];
    assign bus.m1_addr = addr_v[1];
    assign bus.m1_wen  = wen_v[1];
    assign bus.m1_din  = din_v[1];
    assign bus.ahb_slave_ready = rdy;

    function automatic logic [15:0] preload(input int i);
        return 16'(i * 32'h1357) ^ 16'hBEEF;
    endfunction

    // ---------------- slave memory ----------------
    logic [15:0] slave_mem [256];
    logic        mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) slave_mem[i] <= preload(i);
            mem_loaded <= 1'b1;
        end else if (bus.ahb_slave_en && bus.ahb_slave_ready) begin
            if (bus.ahb_slave_wen == 2'b00) begin
                bus.ahb_slave_dout <= slave_mem[bus.ahb_slave_addr[7:0]];
                bus.ahb_slave_resp <= bus.ahb_slave_addr[7];
            end else begin
                if (bus.ahb_slave_wen[0])
                    slave_mem[bus.ahb_slave_addr[7:0]][7:0] <= bus.ahb_slave_din[7:0];
                if (bus.ahb_slave_wen[1])
                    slave_mem[bus.ahb_slave_addr[7:0]][15:8] <= bus.ahb_slave_din[15:8];
            end
        end
    end

    // ---------------- reference model ----------------
    int          m_owner;      // -1 none, else owning requester
    int          m_last;
    int          m_beats;      // accepted beats in current ownership
    int          m_rv;         // requester whose read returns this cycle, -1 none
    logic [15:0] m_pend_rd;
    logic        m_pend_rr;
    logic [15:0] m_hold_rd;
    logic        m_hold_rr;
    logic [15:0] ref_mem [256];
    logic        e_ack [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ack_q0[$], ack_q1[$], rv_q0[$], rv_q1[$];
    logic [15:0] rd_q0[$], rd_q1[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got 0x%0h want 0x%0h", tag, cyc, act, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic model_reset();
        m_owner   = -1;
        m_last    = 1;
        m_beats   = 0;
        m_rv      = -1;
        m_hold_rd = '0;
        m_hold_rr = 1'b0;
        e_ack[0]  = 1'b0;
        e_ack[1]  = 1'b0;
    endtask

    task automatic clear_logs();
        ack_q0.delete(); ack_q1.delete(); rv_q0.delete(); rv_q1.delete();
        rd_q0.delete();  rd_q1.delete();
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 1'b0; lock_v[i] = 1'b0; addr_v[i] = '0;
            wen_v[i] = 2'b00; din_v[i] = '0;
        end
    endtask

    task automatic set_req(input int i, input logic r, input logic l,
                           input logic [15:0] a, input logic [1:0] w, input logic [15:0] d);
        req_v[i] = r; lock_v[i] = l; addr_v[i] = a; wen_v[i] = w; din_v[i] = d;
    endtask

    task automatic retire();
        for (int i = 0; i < 2; i++) if (e_ack[i]) req_v[i] = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_m0_ack"},    32'(bus.m0_ack), 0);
        check({tag, "_m1_ack"},    32'(bus.m1_ack), 0);
        check({tag, "_m0_rvalid"}, 32'(bus.m0_rvalid), 0);
        check({tag, "_m1_rvalid"}, 32'(bus.m1_rvalid), 0);
        check({tag, "_en"},        32'(bus.ahb_slave_en), 0);
        check({tag, "_wen"},       32'(bus.ahb_slave_wen), 0);
        check({tag, "_addr"},      32'(bus.ahb_slave_addr), 0);
        check({tag, "_din"},       32'(bus.ahb_slave_din), 0);
        check({tag, "_rdata"},     32'(bus.rdata), 0);
        check({tag, "_rresp"},     32'(bus.rresp), 0);
    endtask

    // Compare every DUT output against the model for the current cycle.
    task automatic check_cycle();
        logic        exp_en;
        logic [1:0]  exp_wen;
        logic [15:0] exp_addr, exp_din;
        int x;
        x = m_owner;
        e_ack[0] = (x == 0) && req_v[0] && rdy;
        e_ack[1] = (x == 1) && req_v[1] && rdy;
        exp_en = 1'b0; exp_wen = 2'b00; exp_addr = '0; exp_din = '0;
        if (x >= 0) begin
            exp_en   = req_v[x];
            exp_wen  = req_v[x] ? wen_v[x] : 2'b00;
            exp_addr = addr_v[x];
            exp_din  = din_v[x];
        end
        if (m_rv >= 0) begin
            m_hold_rd = m_pend_rd;
            m_hold_rr = m_pend_rr;
        end
        check("m0_ack",    32'(bus.m0_ack), 32'(e_ack[0]));
        check("m1_ack",    32'(bus.m1_ack), 32'(e_ack[1]));
        check("en",        32'(bus.ahb_slave_en), 32'(exp_en));
        check("wen",       32'(bus.ahb_slave_wen), 32'(exp_wen));
        check("addr",      32'(bus.ahb_slave_addr), 32'(exp_addr));
        check("din",       32'(bus.ahb_slave_din), 32'(exp_din));
        check("m0_rvalid", 32'(bus.m0_rvalid), 32'(m_rv == 0));
        check("m1_rvalid", 32'(bus.m1_rvalid), 32'(m_rv == 1));
        check("rdata",     32'(bus.rdata), 32'(m_hold_rd));
        check("rresp",     32'(bus.rresp), 32'(m_hold_rr));
        if (bus.m0_ack) ack_q0.push_back(cyc);
        if (bus.m1_ack) ack_q1.push_back(cyc);
        if (bus.m0_rvalid) begin rv_q0.push_back(cyc); rd_q0.push_back(bus.rdata); end
        if (bus.m1_rvalid) begin rv_q1.push_back(cyc); rd_q1.push_back(bus.rdata); end
    endtask

    // Apply the arbitration rules to decide who owns the next cycle.
    task automatic advance_model();
        int x, o;
        int rv_next;
        logic rel;
        logic [7:0] a;
        rv_next = -1;
        x = m_owner;
        if (x < 0) begin
            if (req_v[0] && req_v[1]) m_owner = 1 - m_last;
            else if (req_v[0])        m_owner = 0;
            else if (req_v[1])        m_owner = 1;
        end else begin
            o = 1 - x;
            a = addr_v[x][7:0];
            if (e_ack[x]) begin
                if (wen_v[x] == 2'b00) begin
                    rv_next   = x;
                    m_pend_rd = ref_mem[a];
                    m_pend_rr = addr_v[x][7];
                end else begin
                    if (wen_v[x][0]) ref_mem[a][7:0]  = din_v[x][7:0];
                    if (wen_v[x][1]) ref_mem[a][15:8] = din_v[x][15:8];
                end
                m_beats++;
            end
            rel = !req_v[x] || (e_ack[x] && (!lock_v[x] || m_beats == MAX_BURST));
            if (rel) begin
                m_last  = x;
                m_beats = 0;
                m_owner = req_v[o] ? o : -1;
            end
        end
        m_rv = rv_next;
    endtask

    task automatic tick();
        cyc++;
        @(negedge clk);
        check_cycle();
        advance_model();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst");
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;
        clear_logs();
    endtask

    // Locked m0 burst against a waiting m1, optionally with a 3-cycle stall.
    task automatic burst_test(input logic stall, input string tag);
        int n0;
        do_reset();
        set_req(0, 1'b1, 1'b1, 16'h0030, 2'b00, 16'h0);
        set_req(1, 1'b1, 1'b0, 16'h0040, 2'b00, 16'h0);
        for (int c = 1; c <= 16; c++) begin
            rdy = !(stall && c >= 5 && c <= 7);
            if (stall && c >= 5 && c <= 7) begin
                #1;
                check({tag, "_stall_en"},  32'(bus.ahb_slave_en), 1);
                check({tag, "_stall_ack"}, 32'(bus.m0_ack), 0);
            end
            tick();
            if (e_ack[0]) addr_v[0] = addr_v[0] + 16'd1;
            if (e_ack[1]) req_v[1] = 1'b0;
        end
        n0 = 0;
        foreach (ack_q0[i]) if (ack_q0[i] < qget(ack_q1, 0)) n0++;
        check({tag, "_m0_beats"},   32'(n0), MAX_BURST);
        check({tag, "_m0_first"},   32'(qget(ack_q0, 0)), 2);
        check({tag, "_m1_ack_cyc"}, 32'(qget(ack_q1, 0)), stall ? 13 : 10);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = preload(i);
        model_reset();

        // single read from reset
        do_reset();
        set_req(0, 1'b1, 1'b0, 16'h0010, 2'b00, 16'h0);
        repeat (4) begin tick(); retire(); end
        check("t1_ack_n",   32'(ack_q0.size()), 1);
        check("t1_ack_cyc", 32'(qget(ack_q0, 0)), 2);
        check("t1_rv_cyc",  32'(qget(rv_q0, 0)), 3);
        check("t1_rdata",   32'(rd_q0.size() > 0 ? rd_q0[0] : 16'hxxxx), 32'(preload(16)));
        check("t1_m1_quiet", 32'(ack_q1.size() + rv_q1.size()), 0);

        // contention from IDLE
        do_reset();
        set_req(0, 1'b1, 1'b0, 16'h0020, 2'b11, 16'h1111);
        set_req(1, 1'b1, 1'b0, 16'h0021, 2'b00, 16'h0);
        repeat (4) begin tick(); retire(); end
        set_req(0, 1'b1, 1'b0, 16'h0022, 2'b00, 16'h0);
        set_req(1, 1'b1, 1'b0, 16'h0023, 2'b00, 16'h0);
        repeat (3) begin tick(); retire(); end
        check("t2_m0_first",  32'(qget(ack_q0, 0)), 2);
        check("t2_m1_next",   32'(qget(ack_q1, 0)), 3);
        check("t2_m0_again",  32'(qget(ack_q0, 1)), 6);

        // locked burst cap, then the same with a ready stall
        burst_test(1'b0, "t3");
        burst_test(1'b1, "t5");

        // write then readback across an ownership switch
        do_reset();
        set_req(0, 1'b1, 1'b1, 16'h0005, 2'b11, 16'h0000);
        set_req(1, 1'b1, 1'b0, 16'h0005, 2'b00, 16'h0);
        tick();
        tick();
        set_req(0, 1'b1, 1'b0, 16'h0005, 2'b01, 16'hA55A);
        repeat (4) begin tick(); retire(); end
        check("t4_m1_ack_cyc", 32'(qget(ack_q1, 0)), 4);
        check("t4_m1_rv_cyc",  32'(qget(rv_q1, 0)), 5);
        check("t4_rdata",      32'(rd_q1.size() > 0 ? rd_q1[0] : 16'hxxxx), 32'h005A);
        check("t4_m0_no_rv",   32'(rv_q0.size()), 0);

        // asynchronous reset in the middle of a read burst
        do_reset();
        set_req(0, 1'b1, 1'b1, 16'h0050, 2'b00, 16'h0);
        tick();
        tick();
        check("t6_pre_en",     32'(bus.ahb_slave_en), 1);
        check("t6_pre_rvalid", 32'(bus.m0_rvalid), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("t6_async");
        model_reset();
        idle_inputs();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;
        clear_logs();
        set_req(0, 1'b1, 1'b0, 16'h0060, 2'b00, 16'h0);
        set_req(1, 1'b1, 1'b0, 16'h0061, 2'b00, 16'h0);
        repeat (4) begin tick(); retire(); end
        check("t6_m0_prio", 32'(qget(ack_q0, 0)), 2);
        check("t6_m1_next", 32'(qget(ack_q1, 0)), 3);

        // randomized traffic
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (req_v[i] && !e_ack[i]) begin
                    if ($urandom_range(0, 15) == 0) req_v[i] = 1'b0;
                end else begin
                    req_v[i]       = ($urandom_range(0, 3) != 0);
                    lock_v[i]      = 1'($urandom_range(0, 1));
                    addr_v[i]      = 16'($urandom);
                    addr_v[i][6:0] = 7'($urandom_range(0, 15));
                    wen_v[i]       = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
                    din_v[i]       = 16'($urandom);
                end
            end
            rdy = ($urandom_range(0, 4) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
